// File: rtl/note_recorder.sv
// rtl/note_recorder.sv - live keypad run-length encoder writing score words to RAM port B
// Samples keys every tick and emits {note, band, len} words, closing each take with a zero terminator.
module note_recorder #(
  parameter int TICK_CYCLES = 3125000,
  parameter int DEPTH       = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keys,
  input  logic [2:0]  band_in,
  input  logic        rec,
  output logic        wr_en,
  output logic [15:0] addr_b,
  output logic [11:0] din,
  output logic        recording,
  output logic        full
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [15:0]   LAST_ADDR = 16'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REC, FLUSH, TERM} state_t;

  state_t        state;
  logic          rec_q;
  logic          rec_edge;
  logic [CW-1:0] tick_cnt;
  logic [3:0]    held_note;
  logic [2:0]    held_band;
  logic [4:0]    len;
  logic [15:0]   keys_hi;
  logic [3:0]    samp_note;
  logic [4:0]    n;
  logic          tick;
  logic          differs;
  logic          at_last;

  // Bit 0 is masked so that a lone key 0 reads as a rest.
  always_comb begin
    keys_hi   = keys & 16'hFFFE;
    samp_note = 4'd0;
    for (int k = 0; k < 16; k++)
      if (keys_hi[k]) samp_note = 4'(k);
  end

  assign tick    = (tick_cnt == TICK_LAST);
  assign n       = len + 5'd1;
  assign differs = (samp_note != held_note) || (band_in != held_band);
  assign at_last = (addr_b == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rec_q     <= rec;
      rec_edge  <= 1'b0;
      tick_cnt  <= '0;
      held_note <= 4'd0;
      held_band <= 3'd0;
      len       <= 5'd0;
      wr_en     <= 1'b0;
      addr_b    <= 16'd0;
      din       <= 12'h000;
      recording <= 1'b0;
      full      <= 1'b0;
    end else begin
      rec_q    <= rec;
      rec_edge <= rec & ~rec_q;
      wr_en    <= 1'b0;
      // Advance past each data word; the terminator leaves addr_b on its own slot.
      if (wr_en && state != IDLE) addr_b <= addr_b + 16'd1;

      case (state)
        IDLE: begin
          recording <= 1'b0;
          if (rec_edge) begin
            addr_b    <= 16'd0;
            full      <= 1'b0;
            tick_cnt  <= '0;
            len       <= 5'd0;
            held_note <= samp_note;
            held_band <= band_in;
            recording <= 1'b1;
            state     <= REC;
          end
        end
        REC: begin
          tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
          if (rec_edge) begin
            state <= FLUSH;
          end else if (tick) begin
            if (differs || n == 5'd31) begin
              if (at_last) begin
                full  <= 1'b1;
                state <= TERM;
              end else begin
                wr_en <= 1'b1;
                din   <= {held_note, held_band, n};
              end
              held_note <= samp_note;
              held_band <= band_in;
              len       <= 5'd0;
            end else begin
              len <= n;
            end
          end
        end
        FLUSH: begin
          if (len != 5'd0) begin
            if (at_last) begin
              full <= 1'b1;
            end else begin
              wr_en <= 1'b1;
              din   <= {held_note, held_band, len};
            end
          end
          state <= TERM;
        end
        TERM: begin
          // Wait out a flush write so writes stay at least one idle cycle apart.
          if (!wr_en) begin
            wr_en <= 1'b1;
            din   <= 12'h000;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_note_recorder.sv
// tb/tb_note_recorder.sv - randomized bench for note_recorder against a run-length score model
module tb_note_recorder;
  localparam int T = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = 16'h0000;
  logic [2:0]  band_in = 3'd0;
  logic        rec = 1'b0;
  logic        wr_en;
  logic [15:0] addr_b;
  logic [11:0] din;
  logic        recording;
  logic        full;

  note_recorder #(.TICK_CYCLES(T), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .band_in(band_in), .rec(rec),
    .wr_en(wr_en), .addr_b(addr_b), .din(din), .recording(recording), .full(full)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_test = "reset";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_test, tag, got, exp);
    end
  endtask

  // Write capture from RAM port B
  int          cap_n = 0;
  logic [15:0] cap_addr [0:31];
  logic [11:0] cap_data [0:31];
  logic        prev_wr = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      check("write_gap", {31'b0, prev_wr}, 32'd0);
      if (cap_n < 32) begin
        cap_addr[cap_n] = addr_b;
        cap_data[cap_n] = din;
      end
      cap_n++;
    end
    prev_wr = wr_en;
  end

  // Stimulus: entry 0 is the sample at start, entry j the sample at tick j
  logic [15:0] key_arr  [0:255];
  logic [2:0]  band_arr [0:255];
  logic [11:0] exp_w [$];

  function automatic logic [3:0] note_of(input logic [15:0] kv);
    for (int b = 15; b >= 1; b--)
      if (kv[b]) return 4'(b);
    return 4'd0;
  endfunction

  function automatic logic [15:0] make_keys(input logic [3:0] note);
    logic [15:0] r;
    r = 16'($urandom);
    if (note == 4'd0) return {15'b0, r[0]};
    return (r & ((16'd1 << note) - 16'd1)) | (16'd1 << note);
  endfunction

  task automatic fill(input int first, input int count, input logic [15:0] kv, input logic [2:0] bv);
    for (int j = first; j < first + count; j++) begin
      key_arr[j]  = kv;
      band_arr[j] = bv;
    end
  endtask

  // Each tick interval holds the sample taken at its start; runs of equal samples
  // become words of at most 31 ticks, and the partial interval after the last tick is lost.
  task automatic build_model(input int k);
    logic [6:0] rv, v;
    int rl;
    exp_w.delete();
    rv = 7'd0;
    rl = 0;
    for (int j = 1; j <= k; j++) begin
      v = {note_of(key_arr[j-1]), band_arr[j-1]};
      if (rl > 0 && v == rv && rl < 31) begin
        rl++;
      end else begin
        if (rl > 0) exp_w.push_back({rv, 5'(rl)});
        rv = v;
        rl = 1;
      end
    end
    if (rl > 0) exp_w.push_back({rv, 5'(rl)});
  endtask

  task automatic record(input int k, input bit do_stop);
    cap_n = 0;
    @(negedge clk);
    keys = key_arr[0]; band_in = band_arr[0]; rec = 1'b1;
    @(negedge clk);
    rec = 1'b0;
    @(negedge clk);
    check("rec_rise", {31'b0, recording}, 32'd1);
    check("start_full", {31'b0, full}, 32'd0);
    check("start_addr", {16'b0, addr_b}, 32'd0);
    for (int j = 1; j <= k; j++) begin
      keys = key_arr[j]; band_in = band_arr[j];
      repeat (T) @(negedge clk);
    end
    if (do_stop) begin
      rec = 1'b1;
      @(negedge clk);
      rec = 1'b0;
    end
  endtask

  task automatic finish_check(input int k);
    int nd;
    build_model(k);
    nd = (exp_w.size() > D - 1) ? D - 1 : exp_w.size();
    for (int c = 0; c < 64 && recording; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("rec_fall", {31'b0, recording}, 32'd0);
    check("nwrites", cap_n, nd + 1);
    for (int i = 0; i < nd; i++) begin
      check("addr", {16'b0, cap_addr[i]}, i);
      check("data", {20'b0, cap_data[i]}, {20'b0, exp_w[i]});
    end
    check("term_addr", {16'b0, cap_addr[nd]}, nd);
    check("term_data", {20'b0, cap_data[nd]}, 32'd0);
    check("full", {31'b0, full}, {31'b0, exp_w.size() > D - 1});
    check("end_addr", {16'b0, addr_b}, nd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, runs, rlen, snap;
    logic [3:0] nt;
    logic [2:0] bd;

    repeat (3) @(negedge clk);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_addr", {16'b0, addr_b}, 32'd0);
    check("rst_din", {20'b0, din}, 32'd0);
    check("rst_recording", {31'b0, recording}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    cur_test = "t1_basic";
    fill(0, 3, 16'h0008, 3'd3);
    fill(3, 3, 16'h0000, 3'd3);
    record(5, 1'b1);
    finish_check(5);
    check("w0_const", {20'b0, cap_data[0]}, 32'h363);
    check("w1_const", {20'b0, cap_data[1]}, 32'h062);

    cur_test = "t2_saturate";
    fill(0, 41, 16'h8001, 3'd2);
    record(40, 1'b1);
    finish_check(40);
    check("w0_const", {20'b0, cap_data[0]}, 32'hF5F);
    check("w1_const", {20'b0, cap_data[1]}, 32'hF49);

    cur_test = "t3_band";
    fill(0, 3, 16'h0020, 3'd1);
    fill(3, 3, 16'h0020, 3'd6);
    record(5, 1'b1);
    finish_check(5);

    cur_test = "t4_no_flush";
    fill(0, 2, 16'h0100, 3'd4);
    fill(2, 1, 16'h0004, 3'd4);
    record(2, 1'b1);
    finish_check(2);

    cur_test = "t5_full";
    for (int j = 0; j <= 8; j++) fill(j, 1, 16'd1 << (j + 1), 3'd0);
    record(8, 1'b0);
    finish_check(8);

    for (int it = 0; it < 6; it++) begin
      cur_test = $sformatf("rand%0d", it);
      do begin
        k = 0;
        runs = $urandom_range(1, 4);
        for (int r = 0; r < runs; r++) begin
          nt = 4'($urandom_range(0, 15));
          bd = 3'($urandom_range(0, 7));
          rlen = $urandom_range(1, 35);
          for (int l = 0; l < rlen; l++) begin
            key_arr[k]  = make_keys(nt);
            band_arr[k] = bd;
            k++;
          end
        end
        build_model(k);
      end while (exp_w.size() > D - 1);
      key_arr[k]  = make_keys(4'($urandom_range(0, 15)));
      band_arr[k] = 3'($urandom_range(0, 7));
      record(k, 1'b1);
      finish_check(k);
    end

    cur_test = "t6_reset";
    fill(0, 6, 16'h0200, 3'd5);
    record(3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rec = 1'b1;
    @(negedge clk);
    check("wr_en", {31'b0, wr_en}, 32'd0);
    check("addr", {16'b0, addr_b}, 32'd0);
    check("din", {20'b0, din}, 32'd0);
    check("recording", {31'b0, recording}, 32'd0);
    check("full", {31'b0, full}, 32'd0);
    snap = cap_n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_restart", {31'b0, recording}, 32'd0);
    check("no_term", cap_n, snap);
    rec = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
